// File: rtl/eflag_pkg.sv
// eflag_pkg: shared definitions for the speculative EFLAGS checkpoint block.
//   - architectural flag bit positions
//   - mask of reserved (always-zero) bits in the 18-bit flag image
//   - p_op encoding that selects the IRET flag source
//   - flag-vector typedef
package eflag_pkg;

  localparam int CF = 0;
  localparam int PF = 1;
  localparam int AF = 2;
  localparam int ZF = 3;
  localparam int SF = 4;
  localparam int DF = 7;
  localparam int OF = 8;

  localparam int EFLAG_W = 18;

  // Low nine bits that hold real flags; everything else reads as zero.
  localparam logic [8:0] LIVE_BITS = 9'((1 << CF) | (1 << PF) | (1 << AF) | (1 << ZF) |
                                        (1 << SF) | (1 << DF) | (1 << OF));

  localparam logic [EFLAG_W-1:0] RSVD_MASK = ~EFLAG_W'(LIVE_BITS);

  localparam logic [1:0] P_OP_IRET = 2'b11;

  typedef logic [EFLAG_W-1:0] eflags_t;

endpackage

// File: rtl/eflag_hist_fifo.sv
// eflag_hist_fifo: circular history queue of flag images, oldest at head.
//   clk, rst   : clock, async active-high reset
//   push, din  : append din at tail (ignored while full)
//   pop        : drop head (ignored while empty)
//   clear      : empty the queue; wins over push/pop
//   head       : value at head (undefined when empty)
//   cnt        : number of queued entries
//   full       : registered, cnt==DEPTH
//   empty      : cnt==0
module eflag_hist_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          r_full;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_nxt;

  assign w_push = push & ~r_full;
  assign w_pop  = pop & (r_cnt != '0);

  assign w_cnt_nxt = clear ? '0 : (r_cnt + CW'(w_push) - CW'(w_pop));

  // Pointers are log2(DEPTH) wide, so they wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == CW'(DEPTH));
      if (clear) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + PW'(1);
        if (w_pop)  r_rd <= r_rd + PW'(1);
      end
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  assign head  = r_mem[r_rd];
  assign cnt   = r_cnt;
  assign full  = r_full;
  assign empty = (r_cnt == '0);

endmodule

// File: rtl/eflag_spec_ckpt.sv
// eflag_spec_ckpt: speculative EFLAGS register with in-order history and a
// committed copy. Each accepted Ex instruction produces a merged flag image
// that becomes the new speculative value and is queued; writeback retires
// queue entries into the committed copy; a resteer restores speculative from
// committed and flushes the queue.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   val             instruction in Ex is valid
//   cc_inval        instruction leaves flags unchanged (still queued)
//   cc_in, fmask    ALU flags and per-bit write mask
//   p_op, op2       p_op==IRET selects op2 as the flag source
//   valid_wb        oldest queued instruction retires
//   is_resteer      flush and restore from committed
//   cc_out          speculative flags (registered)
//   cc_commit       committed flags (registered)
//   ready           queue not full (registered)
//   hist_cnt        queued entries
//   wb_underflow    sticky: retire seen with empty queue
//
// Build option: define EFLAG_TRACE_EN to compile a simulation-only event log
// printed to the simulator console. Ports are identical either way.
module eflag_spec_ckpt
  import eflag_pkg::*;
#(
  parameter int                FLAG_W     = 18,
  parameter int                HIST_DEPTH = 4,
  parameter logic [FLAG_W-1:0] RESET_VAL  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          val,
  input  logic                          cc_inval,
  input  logic [FLAG_W-1:0]             cc_in,
  input  logic [FLAG_W-1:0]             fmask,
  input  logic [1:0]                    p_op,
  input  logic [FLAG_W-1:0]             op2,
  input  logic                          valid_wb,
  input  logic                          is_resteer,
  output logic [FLAG_W-1:0]             cc_out,
  output logic [FLAG_W-1:0]             cc_commit,
  output logic                          ready,
  output logic [$clog2(HIST_DEPTH):0]   hist_cnt,
  output logic                          wb_underflow
);

  localparam logic [FLAG_W-1:0] LIVE_MASK = FLAG_W'(LIVE_BITS);

  logic [FLAG_W-1:0] r_cc_out;
  logic [FLAG_W-1:0] r_cc_commit;
  logic              r_uf;

  logic              w_accept;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FLAG_W-1:0] w_src;
  logic [FLAG_W-1:0] w_nxt;
  logic [FLAG_W-1:0] w_head;
  logic [FLAG_W-1:0] w_commit_nxt;

  assign ready    = ~w_full;
  assign w_accept = val & ready & ~is_resteer;
  assign w_pop    = valid_wb & ~w_empty;

  assign w_src = (p_op == P_OP_IRET) ? op2 : cc_in;
  assign w_nxt = (cc_inval ? r_cc_out : ((w_src & fmask) | (r_cc_out & ~fmask))) & LIVE_MASK;

  // A resteer restores from the committed value *after* this cycle's retire.
  assign w_commit_nxt = w_pop ? w_head : r_cc_commit;

  eflag_hist_fifo #(
    .DEPTH (HIST_DEPTH),
    .W     (FLAG_W)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept),
    .pop   (w_pop),
    .clear (is_resteer),
    .din   (w_nxt),
    .head  (w_head),
    .cnt   (hist_cnt),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cc_out    <= RESET_VAL;
      r_cc_commit <= RESET_VAL;
      r_uf        <= 1'b0;
    end else begin
      r_cc_commit <= w_commit_nxt;
      if (is_resteer)    r_cc_out <= w_commit_nxt;
      else if (w_accept) r_cc_out <= w_nxt;
      if (valid_wb & w_empty) r_uf <= 1'b1;
    end
  end

  assign cc_out       = r_cc_out;
  assign cc_commit    = r_cc_commit;
  assign wb_underflow = r_uf;

`ifdef EFLAG_TRACE_EN
  longint      trc_cyc;

  function automatic string fl_str(input logic [FLAG_W-1:0] f);
    return $sformatf("cf=%b pf=%b af=%b zf=%b sf=%b df=%b of=%b",
                     f[CF], f[PF], f[AF], f[ZF], f[SF], f[DF], f[OF]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      trc_cyc <= 0;
    end else begin
      trc_cyc <= trc_cyc + 1;
      if (w_pop)
        $display("%0d RETIRE  old[%s] new[%s] cnt=%0d", trc_cyc,
                 fl_str(r_cc_commit), fl_str(w_head), hist_cnt);
      if (is_resteer)
        $display("%0d RESTEER old[%s] new[%s] cnt=%0d", trc_cyc,
                 fl_str(r_cc_out), fl_str(w_commit_nxt), hist_cnt);
      else if (w_accept)
        $display("%0d ACCEPT  old[%s] new[%s] cnt=%0d", trc_cyc,
                 fl_str(r_cc_out), fl_str(w_nxt), hist_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_eflag_spec_ckpt.sv
module tb_eflag_spec_ckpt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        val = 1'b0, cc_inval = 1'b0, valid_wb = 1'b0, is_resteer = 1'b0;
  logic [17:0] cc_in = '0, fmask = '0, op2 = '0;
  logic [1:0]  p_op = '0;
  logic [17:0] cc_out, cc_commit;
  logic        ready, wb_underflow;
  logic [2:0]  hist_cnt;

  int n_chk = 0;
  int n_err = 0;

  eflag_spec_ckpt dut (
    .clk(clk), .rst(rst), .val(val), .cc_inval(cc_inval), .cc_in(cc_in),
    .fmask(fmask), .p_op(p_op), .op2(op2), .valid_wb(valid_wb),
    .is_resteer(is_resteer), .cc_out(cc_out), .cc_commit(cc_commit),
    .ready(ready), .hist_cnt(hist_cnt), .wb_underflow(wb_underflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [17:0] m_out, m_commit;
  logic        m_uf;
  logic [17:0] m_q[$];

  initial begin
    m_out = '0; m_commit = '0; m_uf = 1'b0; m_q.delete();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_out = '0; m_commit = '0; m_uf = 1'b0; m_q.delete();
      end else begin
        logic        acc;
        logic [17:0] src, nxt;
        acc = val && (m_q.size() < 4) && !is_resteer;
        src = (p_op == 2'b11) ? op2 : cc_in;
        nxt = cc_inval ? m_out : ((src & fmask) | (m_out & ~fmask));
        nxt = nxt & 18'h0019F;
        if (valid_wb) begin
          if (m_q.size() == 0) m_uf = 1'b1;
          else m_commit = m_q.pop_front();
        end
        if (is_resteer) begin
          m_out = m_commit;
          m_q.delete();
        end else if (acc) begin
          m_q.push_back(nxt);
          m_out = nxt;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("m.cc_out",       32'(cc_out),       32'(m_out));
      check("m.cc_commit",    32'(cc_commit),    32'(m_commit));
      check("m.hist_cnt",     32'(hist_cnt),     32'(m_q.size()));
      check("m.ready",        32'(ready),        32'(m_q.size() < 4));
      check("m.wb_underflow", 32'(wb_underflow), 32'(m_uf));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic v, input logic inv, input logic [17:0] ci,
                      input logic [17:0] fm, input logic [1:0] po, input logic [17:0] o2,
                      input logic wb, input logic rs);
    val = v; cc_inval = inv; cc_in = ci; fmask = fm; p_op = po; op2 = o2;
    valid_wb = wb; is_resteer = rs;
    @(posedge clk); #1;
    val = 0; cc_inval = 0; valid_wb = 0; is_resteer = 0; p_op = 0;
  endtask

  task automatic push(input logic [17:0] v, input logic wb);
    step(1, 0, v, 18'h3FFFF, 2'b00, 18'h0, wb, 0);
  endtask

  initial begin
    logic [17:0] wrapv [6];
    wrapv[0] = 18'h080; wrapv[1] = 18'h100; wrapv[2] = 18'h003;
    wrapv[3] = 18'h005; wrapv[4] = 18'h009; wrapv[5] = 18'h011;

    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst.cc_out", 32'(cc_out), 32'h0);
    check("rst.ready",  32'(ready),  32'h1);
    check("rst.cnt",    32'(hist_cnt), 32'h0);
    check("rst.uf",     32'(wb_underflow), 32'h0);

    // masked update
    step(1, 0, 18'h1FF, 18'h011, 2'b00, 18'h0, 0, 0);
    check("mask.cc_out", 32'(cc_out), 32'h011);
    check("mask.cnt",    32'(hist_cnt), 32'h1);
    step(1, 1, 18'h3FFFF, 18'h3FFFF, 2'b00, 18'h0, 0, 0);
    check("inval.cc_out", 32'(cc_out), 32'h011);
    check("inval.cnt",    32'(hist_cnt), 32'h2);

    // IRET
    step(1, 0, 18'h0, 18'h1FF, 2'b11, 18'h3FFFF, 0, 0);
    check("iret.cc_out", 32'(cc_out), 32'h19F);

    // push+pop keeps depth at 3, commit gets first entry
    step(1, 0, 18'h00C, 18'h0FF, 2'b00, 18'h0, 1, 0);
    check("pp.cnt",    32'(hist_cnt), 32'h3);
    check("pp.commit", 32'(cc_commit), 32'h011);
    check("pp.cc_out", 32'(cc_out), 32'h10C);

    // async reset mid-cycle with 3 queued
    #1 rst = 1;
    #1;
    check("arst.cc_out", 32'(cc_out), 32'h0);
    check("arst.commit", 32'(cc_commit), 32'h0);
    check("arst.cnt",    32'(hist_cnt), 32'h0);
    check("arst.ready",  32'(ready), 32'h1);
    @(posedge clk); #1 rst = 0;

    // full / drop / wrap
    push(18'h001, 0); push(18'h002, 0); push(18'h004, 0); push(18'h008, 0);
    check("full.ready", 32'(ready), 32'h0);
    push(18'h010, 0);
    check("drop.cc_out", 32'(cc_out), 32'h008);
    check("drop.cnt",    32'(hist_cnt), 32'h4);
    push(wrapv[0], 1);
    check("fullpop.cnt",    32'(hist_cnt), 32'h3);
    check("fullpop.commit", 32'(cc_commit), 32'h001);
    check("fullpop.cc_out", 32'(cc_out), 32'h008);
    for (int i = 1; i < 6; i++) push(wrapv[i], 1);
    check("wrap.commit", 32'(cc_commit), 32'h003);
    check("wrap.cnt",    32'(hist_cnt), 32'h3);
    repeat (3) step(0, 0, 18'h0, 18'h0, 2'b00, 18'h0, 1, 0);
    check("drain.commit", 32'(cc_commit), 32'h011);
    check("drain.cnt",    32'(hist_cnt), 32'h0);

    // resteer with same-cycle retire and val
    push(18'h081, 0); push(18'h102, 0); push(18'h01C, 0);
    step(1, 0, 18'h0FF, 18'h3FFFF, 2'b00, 18'h0, 1, 1);
    check("rs.commit", 32'(cc_commit), 32'h081);
    check("rs.cc_out", 32'(cc_out), 32'h081);
    check("rs.cnt",    32'(hist_cnt), 32'h0);
    check("rs.ready",  32'(ready), 32'h1);

    // underflow
    step(0, 0, 18'h0, 18'h0, 2'b00, 18'h0, 1, 0);
    check("uf.set",    32'(wb_underflow), 32'h1);
    check("uf.commit", 32'(cc_commit), 32'h081);
    step(1, 0, 18'h004, 18'h3FFFF, 2'b00, 18'h0, 1, 0);
    check("uf.acc.cnt", 32'(hist_cnt), 32'h1);
    check("uf.sticky",  32'(wb_underflow), 32'h1);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1 check("uf.clr", 32'(wb_underflow), 32'h0);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
